// File: rtl/io_event_pkg.sv
// Shared definitions for the front-panel event queue: entry field
// offsets, the drop-counter width and the entry packing helper.
package io_event_pkg;

  localparam int unsigned TS_LSB  = 0;
  localparam int unsigned OVF_BIT = 31;
  localparam int unsigned DROP_W  = 16;
  localparam int unsigned ENTRY_W = 32;

  // Button mask sits directly above the timestamp.
  function automatic int unsigned BTN_LSB(input int unsigned ts_width);
    return TS_LSB + ts_width;
  endfunction

  // Switch snapshot sits directly above the button mask.
  function automatic int unsigned SW_LSB(input int unsigned n_buttons,
                                         input int unsigned ts_width);
    return BTN_LSB(ts_width) + n_buttons;
  endfunction

  // Callers pass zero-extended fields; unused bits stay 0.
  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [ENTRY_W-1:0] ts,
    input logic [ENTRY_W-1:0] btn,
    input logic [ENTRY_W-1:0] sw,
    input logic               ovf,
    input int unsigned        n_buttons,
    input int unsigned        ts_width
  );
    logic [ENTRY_W-1:0] e;
    e = (ts << TS_LSB) | (btn << BTN_LSB(ts_width)) | (sw << SW_LSB(n_buttons, ts_width));
    e[OVF_BIT] = ovf;
    return e;
  endfunction

endpackage

// File: rtl/io_event_fifo_ring.sv
// Power-of-two ring buffer with show-ahead read.
// Ports: clk, rst_n, push/pop/flush controls, din write data,
// dout head entry (combinational), empty/full/count registered status.
module event_ring #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic          do_push, do_pop;

  // Pop-and-push while full is legal; pop while empty is ignored.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next pointers; flush wins over push and pop.
  always_comb begin
    wr_nxt = wr_ptr;
    rd_nxt = rd_ptr;
    if (flush) begin
      wr_nxt = '0;
      rd_nxt = '0;
    end else begin
      if (do_push) wr_nxt = wr_ptr + PW'(1);
      if (do_pop)  rd_nxt = rd_ptr + PW'(1);
    end
  end

  // Pointers, storage and registered status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
      empty  <= (wr_nxt == rd_nxt);
      full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
      count  <= wr_nxt - rd_nxt;
    end
  end

  assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/io_event_fifo.sv
// Front-panel event queue: timestamps button pulses and switch changes
// into 32-bit entries and presents them to the CPU with show-ahead pop.
// Ports: clk, rst_n, buttons (pulses), switches (levels), flush, rd_en,
// dout (head entry), empty, full, count, drop_count (saturating).
module io_event_fifo
  import io_event_pkg::*;
#(
  parameter int unsigned N_BUTTONS   = 4,
  parameter int unsigned N_SWITCHES  = 2,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TS_WIDTH    = 16,
  parameter int unsigned TS_PRESCALE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_BUTTONS-1:0]      buttons,
  input  logic [N_SWITCHES-1:0]     switches,
  input  logic                      flush,
  input  logic                      rd_en,
  output logic [31:0]               dout,
  output logic                      empty,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count,
  output logic [DROP_W-1:0]         drop_count
);

  localparam int unsigned PSW = (TS_PRESCALE > 1) ? $clog2(TS_PRESCALE) : 1;

  logic [TS_WIDTH-1:0]   ts;
  logic [PSW-1:0]        presc;
  logic                  tick;
  logic                  armed;
  logic [N_SWITCHES-1:0] sw_prev;
  logic                  ovf_pend;
  logic                  sw_event, ev, push, drop;
  logic [31:0]           entry;

  assign tick     = (presc == PSW'(TS_PRESCALE - 1));
  assign sw_event = armed && (switches != sw_prev);
  assign ev       = (|buttons) || sw_event;
  assign push     = ev && (!full || rd_en);
  assign drop     = ev && full && !rd_en;
  assign entry    = pack_entry(32'(ts), 32'(buttons), 32'(switches), ovf_pend,
                               N_BUTTONS, TS_WIDTH);

  // Prescaled free-running timestamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      ts    <= '0;
    end else begin
      presc <= tick ? '0 : presc + PSW'(1);
      ts    <= ts + TS_WIDTH'(tick);
    end
  end

  // Switch change detection; the first cycle after reset only primes sw_prev.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      sw_prev <= '0;
    end else begin
      armed   <= 1'b1;
      sw_prev <= switches;
    end
  end

  // Overflow marker for the next accepted entry and saturating drop count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_pend   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (flush)     ovf_pend <= 1'b0;
      else if (drop) ovf_pend <= 1'b1;
      else if (push) ovf_pend <= 1'b0;
      if (drop && (drop_count != '1)) drop_count <= drop_count + DROP_W'(1);
    end
  end

  event_ring #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_ring (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (rd_en),
    .flush (flush),
    .din   (entry),
    .dout  (dout),
    .empty (empty),
    .full  (full),
    .count (count)
  );

endmodule

// File: tb/tb_io_event_fifo.sv
module tb_io_event_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  buttons = '0;
  logic [1:0]  switches = '0;
  logic        flush = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] dout;
  logic        empty, full;
  logic [3:0]  count;
  logic [15:0] drop_count;

  logic [3:0]  buttons2 = '0;
  logic [1:0]  switches2 = '0;
  logic        flush2 = 1'b0;
  logic        rd_en2 = 1'b0;
  logic [31:0] dout2;
  logic        empty2, full2;
  logic [3:0]  count2;
  logic [15:0] drop_count2;

  int n_checks = 0;
  int n_fail   = 0;
  int edges    = 0;

  always #5 clk = ~clk;

  io_event_fifo u_dut (
    .clk(clk), .rst_n(rst_n), .buttons(buttons), .switches(switches),
    .flush(flush), .rd_en(rd_en), .dout(dout), .empty(empty), .full(full),
    .count(count), .drop_count(drop_count)
  );

  io_event_fifo #(.TS_WIDTH(4), .TS_PRESCALE(3)) u_dut_ts (
    .clk(clk), .rst_n(rst_n), .buttons(buttons2), .switches(switches2),
    .flush(flush2), .rd_en(rd_en2), .dout(dout2), .empty(empty2), .full(full2),
    .count(count2), .drop_count(drop_count2)
  );

  typedef struct {
    logic [3:0] btn;
    logic       rd;
    int         exp_count;
    logic       exp_full;
    int         exp_drop;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    edges++;
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
  endtask

  initial begin
    logic [31:0] te;
    logic [31:0] exp_e;
    int e1;

    // Fill table: 10 pushes into depth 8, pop, push with overflow mark, pop+push while full.
    for (int i = 0; i < 10; i++) begin
      tbl[i].btn       = 4'(i + 1);
      tbl[i].rd        = 1'b0;
      tbl[i].exp_count = (i + 1 > 8) ? 8 : i + 1;
      tbl[i].exp_full  = (i + 1 >= 8);
      tbl[i].exp_drop  = (i + 1 > 8) ? i + 1 - 8 : 0;
    end
    tbl[10] = '{btn: 4'h0, rd: 1'b1, exp_count: 7, exp_full: 1'b0, exp_drop: 2};
    tbl[11] = '{btn: 4'hB, rd: 1'b0, exp_count: 8, exp_full: 1'b1, exp_drop: 2};
    tbl[12] = '{btn: 4'hC, rd: 1'b1, exp_count: 8, exp_full: 1'b1, exp_drop: 2};

    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_dout", dout, 32'd0);

    // Button press at timestamp 5.
    repeat (5) step();
    buttons = 4'b0010;
    step();
    buttons = '0;
    chk("btn_empty", 32'(empty), 32'd0);
    chk("btn_dout", dout, 32'h0002_0005);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("btn_pop_empty", 32'(empty), 32'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("pop_while_empty_count", 32'(count), 32'd0);

    // Switch change together with a button pulse gives one entry.
    te = 32'(edges);
    switches = 2'b10;
    buttons  = 4'b0001;
    step();
    buttons = '0;
    exp_e = 32'h0021_0000 | (te & 32'h0000_FFFF);
    chk("sw_btn_dout", dout, exp_e);
    chk("sw_btn_count", 32'(count), 32'd1);
    step();
    chk("sw_held_count", 32'(count), 32'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("sw_pop_empty", 32'(empty), 32'd1);

    // Table-driven fill / overflow sequence.
    switches = 2'b00;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      buttons = tbl[i].btn;
      rd_en   = tbl[i].rd;
      step();
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
      chk($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].exp_full));
      chk($sformatf("tbl%0d_drop", i), 32'(drop_count), 32'(tbl[i].exp_drop));
    end
    buttons = '0;
    rd_en   = 1'b0;

    // Drain: entries 3..8, then B (overflow marked), then C (clear).
    for (int i = 3; i <= 8; i++) begin
      chk($sformatf("drain%0d_btn", i), 32'(dout[19:16]), 32'(i));
      chk($sformatf("drain%0d_ovf", i), 32'(dout[31]), 32'd0);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
    end
    chk("ovf_entry_btn", 32'(dout[19:16]), 32'hB);
    chk("ovf_entry_bit31", 32'(dout[31]), 32'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("after_ovf_btn", 32'(dout[19:16]), 32'hC);
    chk("after_ovf_bit31", 32'(dout[31]), 32'd0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("drained_empty", 32'(empty), 32'd1);

    // Refill with one drop, then flush alongside an event and a read.
    for (int i = 0; i < 9; i++) begin
      buttons = 4'h1;
      step();
    end
    buttons = '0;
    chk("refill_full", 32'(full), 32'd1);
    chk("refill_drop", 32'(drop_count), 32'd3);
    buttons = 4'h7;
    rd_en   = 1'b1;
    flush   = 1'b1;
    step();
    buttons = '0;
    rd_en   = 1'b0;
    flush   = 1'b0;
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_drop_kept", 32'(drop_count), 32'd3);
    buttons = 4'h5;
    step();
    buttons = '0;
    chk("post_flush_btn", 32'(dout[19:16]), 32'h5);
    chk("post_flush_bit31", 32'(dout[31]), 32'd0);
    chk("post_flush_count", 32'(count), 32'd1);

    // Asynchronous reset mid-operation.
    rst_n = 1'b0;
    #2;
    chk("async_rst_empty", 32'(empty), 32'd1);
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_drop", 32'(drop_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;

    // Prescaled, wrapping timestamp on the second instance.
    repeat (7) step();
    e1 = edges;
    buttons2 = 4'b0001;
    step();
    buttons2 = '0;
    repeat (47) step();
    buttons2 = 4'b0010;
    step();
    buttons2 = '0;
    chk("ts_count", 32'(count2), 32'd2);
    chk("ts_first_ts", 32'(dout2[3:0]), 32'((e1 / 3) % 16));
    chk("ts_first_dout", dout2, 32'h0000_0012);
    rd_en2 = 1'b1;
    step();
    rd_en2 = 1'b0;
    chk("ts_second_ts", 32'(dout2[3:0]), 32'(((e1 + 48) / 3) % 16));
    chk("ts_second_dout", dout2, 32'h0000_0022);

    // Switch level held steady from reset produces no entry.
    rst_n = 1'b0;
    switches = 2'b10;
    do_reset();
    repeat (4) step();
    chk("sw_steady_empty", 32'(empty), 32'd1);
    chk("sw_steady_count", 32'(count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
